fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side consumer for the async FIFO. Runs in the FIFO read clock domain and drains a commanded burst of words.
//  Drives FIFO_r_en from FIFO_empty and free space in a 2-entry skid buffer, then presents the words downstream on a valid/ready stream.
//  Marks the last word of the burst and pulses done when the burst completes.
// PARAMETERS
//  DATA_W  16  word width; must match the FIFO data width
//  CNT_W   8   burst-length counter width; maximum burst is 2**CNT_W-1 words
// PORTS
//  FIFO_r_clk      in   1       read-domain clock; all logic on its rising edge
//  FIFO_r_reset_n  in   1       asynchronous, active-low reset
//  start           in   1       burst request; sampled only in IDLE
//  burst_len       in   CNT_W   words to read; latched when start is accepted
//  busy            out  1       high from the cycle after start is accepted until done
//  done            out  1       one-cycle pulse when the burst completes
//  FIFO_empty      in   1       FIFO empty flag, read domain
//  FIFO_r_en       out  1       FIFO read strobe
//  fifo_rdata      in   DATA_W  FIFO read data; valid the cycle after FIFO_r_en
//  m_data          out  DATA_W  stream data (head of skid buffer)
//  m_valid         out  1       stream valid
//  m_ready         in   1       stream ready
//  m_last          out  1       high with m_valid on the final word of the burst
//  words_left      out  CNT_W   words not yet handed off downstream in the current burst
// BEHAVIOUR
//  Reset values: busy, done, FIFO_r_en, m_valid, m_last = 0; m_data, words_left = 0; FSM = IDLE.
//  Reset mid-burst: all state clears; in-flight and buffered words are discarded (FIFO is reset with this block).
//  FSM states: IDLE -> RUN -> FLUSH -> IDLE.
//   IDLE: on start=1 with burst_len!=0, latch the length into issue_cnt and words_left, then go to RUN.
//   IDLE: on start=1 with burst_len==0, no read is issued and done pulses the next cycle.
//   RUN: issue reads until issue_cnt reaches 0, then go to FLUSH.
//   FLUSH: when words_left reaches 0, pulse done for 1 cycle, drop busy in that same cycle, go to IDLE.
//   start while busy is ignored.
//  Issue rule: FIFO_r_en = (state==RUN) && !FIFO_empty && issue_cnt!=0 && (occ + inflight - pop) < 2.
//   occ: skid-buffer occupancy, 0..2.
//   inflight: registered copy of FIFO_r_en.
//   pop: m_valid && m_ready.
//   FIFO_r_en is combinational; occ never exceeds 2.
//  Latency, start accepted in cycle T:
//   FIFO_r_en no earlier than T+1; fifo_rdata captured at the end of T+2; m_valid no earlier than T+3.
//   Steady-state throughput is 1 word/clk with m_ready=1 and the FIFO non-empty.
//  Skid buffer: 2-entry FIFO, delivered in order.
//   Capture and pop in the same cycle leave occ unchanged.
//   m_data/m_valid hold stable while m_valid=1 && m_ready=0.
//  FIFO_empty mid-burst: issuing stalls and resumes without loss; no timeout.
//  Counters: words_left decrements on each pop; m_last = m_valid && words_left==1.
//  Counters never wrap below 0.
// CONFIGURATION
//  FIFO_RD_CHECKSUM_EN defined:
//   Adds port checksum (out, DATA_W): sum mod 2**DATA_W of all popped words in the current burst.
//   Cleared to 0 on start accept and on reset; final value is valid in the done cycle and held until the next start.
//  FIFO_RD_CHECKSUM_EN undefined: no checksum port and no checksum logic; all other behaviour identical.
// TESTING
//  Reset: assert FIFO_r_reset_n=0 mid-clock -> all outputs 0 immediately, with no clock edge needed.
//  Basic burst: FIFO preloaded with 0x1111..0x8888, burst_len=8, m_ready=1.
//   -> 8 words delivered in order; FIFO_r_en high 8 cycles total; m_last on 0x8888.
//   -> done pulse 1 cycle after the last handshake; busy falls with done.
//  Backpressure: 16 words preloaded, burst_len=16, m_ready pattern 1,0,0,1 repeating.
//   -> no loss or duplication; occ<=2 always; m_data stable while stalled.
//  Empty stall: FIFO holds 3 words, burst_len=5.
//   -> 3 words delivered; FIFO_r_en stays 0 while empty; done absent.
//   -> write 2 more words -> remaining 2 delivered, then done.
//  Zero length: start with burst_len=0 -> no FIFO_r_en, busy stays 0, done 1 cycle after start.
//  Mid-burst reset: burst_len=10, reset after 4 handshakes -> outputs cleared.
//   -> a new start with burst_len=2 completes normally.
//   -> with FIFO_RD_CHECKSUM_EN: words 0x1111,0x2222,0x3333,0x4444 give checksum=0xAAAA at done.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Read-side bundle for fifo_burst_reader: FIFO read port plus downstream valid/ready stream.
// master = the burst reader, slave = FIFO and stream consumer.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              FIFO_empty;
  logic              FIFO_r_en;
  logic [DATA_W-1:0] fifo_rdata;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  FIFO_empty,
    input  fifo_rdata,
    input  m_ready,
    output FIFO_r_en,
    output m_data,
    output m_valid,
    output m_last
  );

  modport slave (
    output FIFO_empty,
    output fifo_rdata,
    output m_ready,
    input  FIFO_r_en,
    input  m_data,
    input  m_valid,
    input  m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a commanded burst from the async FIFO read port into a 2-entry skid buffer and a
// valid/ready stream. Optional running checksum of popped words under FIFO_RD_CHECKSUM_EN.
module fifo_burst_reader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                FIFO_r_clk,
  input  logic                FIFO_r_reset_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    burst_len,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    words_left,
  fifo_burst_reader_if.master bus
`ifdef FIFO_RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_words_left;
  logic              r_inflight;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;

  logic              w_pop;
  logic              w_push;
  logic              w_rd_en;
  logic              w_accept;
  logic [2:0]        w_pending;

  assign w_pop     = (r_occ != 2'd0) && bus.m_ready;
  assign w_push    = r_inflight;
  assign w_accept  = (r_state == StIdle) && start;
  // Slots already claimed once this cycle's pop is accounted for; keeps occ <= 2.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en   = (r_state == StRun) && !bus.FIFO_empty && (r_issue_cnt != '0) &&
                     (w_pending < 3'd2);

  assign bus.FIFO_r_en = w_rd_en;
  assign bus.m_valid   = (r_occ != 2'd0);
  assign bus.m_data    = r_buf0;
  assign bus.m_last    = (r_occ != 2'd0) && (r_words_left == CNT_W'(1));
  assign busy          = r_busy;
  assign done          = r_done;
  assign words_left    = r_words_left;

  always_ff @(posedge FIFO_r_clk or negedge FIFO_r_reset_n) begin
    if (!FIFO_r_reset_n) begin
      r_state      <= StIdle;
      r_issue_cnt  <= '0;
      r_words_left <= '0;
      r_inflight   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_issue_cnt <= r_issue_cnt - CNT_W'(1);
      end
      if (w_pop && (r_words_left != '0)) begin
        r_words_left <= r_words_left - CNT_W'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (burst_len != '0) begin
              r_issue_cnt  <= burst_len;
              r_words_left <= burst_len;
              r_busy       <= 1'b1;
              r_state      <= StRun;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_rd_en && (r_issue_cnt == CNT_W'(1))) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if ((r_words_left == '0) || (w_pop && (r_words_left == CNT_W'(1)))) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Skid buffer: r_buf0 is the head; capture and pop together keep occupancy unchanged.
  always_ff @(posedge FIFO_r_clk or negedge FIFO_r_reset_n) begin
    if (!FIFO_r_reset_n) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= bus.fifo_rdata;
          end else begin
            r_buf1 <= bus.fifo_rdata;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.fifo_rdata;
          end else begin
            r_buf0 <= bus.fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  assign checksum = r_checksum;

  always_ff @(posedge FIFO_r_clk or negedge FIFO_r_reset_n) begin
    if (!FIFO_r_reset_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + r_buf0;
    end
  end
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: FIFO model, stream monitor and hand-computed checks.
// Also covers the checksum port when FIFO_RD_CHECKSUM_EN is defined.
module tb_fifo_burst_reader;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              start     = 1'b0;
  logic [CNT_W-1:0]  burst_len = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_left;
`ifdef FIFO_RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int vectors     = 0;
  int miscompares = 0;

  fifo_burst_reader_if #(.DATA_W(DATA_W)) bus ();

  fifo_burst_reader #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .FIFO_r_clk     (clk),
    .FIFO_r_reset_n (rst_n),
    .start          (start),
    .burst_len      (burst_len),
    .busy           (busy),
    .done           (done),
    .words_left     (words_left),
    .bus            (bus)
`ifdef FIFO_RD_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, emptied by reset.
  logic [DATA_W-1:0] mem [256];
  logic [7:0]        wr_ptr  = 8'd0;
  logic [7:0]        rd_ptr  = 8'd0;
  logic [DATA_W-1:0] rdata_q = '0;

  assign bus.FIFO_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_rdata = rdata_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= wr_ptr;
      rdata_q <= '0;
    end else if (bus.FIFO_r_en) begin
      rdata_q <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
    end
  end

  // Downstream ready: always 1, or pattern 1,0,0,1 in backpressure mode.
  logic bp_mode = 1'b0;
  logic rdy     = 1'b1;
  int   pat     = 0;

  assign bus.m_ready = rdy;

  always @(posedge clk) begin
    #1;
    rdy <= bp_mode ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
    pat <= pat + 1;
  end

  // Stream monitor, sampled mid-cycle.
  logic [DATA_W-1:0] rx_q [$];
  int                cyc        = 0;
  int                hs_cyc     = -1;
  int                done_cyc   = -1;
  int                ren_cnt    = 0;
  int                ren_empty  = 0;
  int                last_cnt   = 0;
  int                stall_viol = 0;
  int                occ_max    = 0;
  logic [DATA_W-1:0] last_data  = '0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_stall = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_valid && bus.m_ready) begin
      rx_q.push_back(bus.m_data);
      hs_cyc <= cyc;
      if (bus.m_last) begin
        last_cnt  <= last_cnt + 1;
        last_data <= bus.m_data;
      end
    end
    if (bus.FIFO_r_en) ren_cnt <= ren_cnt + 1;
    if (bus.FIFO_r_en && bus.FIFO_empty) ren_empty <= ren_empty + 1;
    if (done) done_cyc <= cyc;
    if (int'(dut.r_occ) > occ_max) occ_max <= int'(dut.r_occ);
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) begin
        stall_viol <= stall_viol + 1;
      end
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic start_burst(input logic [CNT_W-1:0] len);
    tick();
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output logic seen, output logic busy_v);
    seen   = 1'b0;
    busy_v = 1'bx;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen   = 1'b1;
        busy_v = busy;
        break;
      end
    end
  endtask

  initial begin
    int   base;
    int   base_ren;
    int   base_last;
    int   base_done;
    logic seen;
    logic busy_v;

    // Asynchronous reset mid-clock, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset_outputs", {16'd0, busy, done, bus.FIFO_r_en, bus.m_valid, bus.m_last, 3'd0,
                            words_left}, 32'd0);
    check("reset_m_data", {16'd0, bus.m_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic burst of 8 words.
    for (int i = 1; i <= 8; i++) push(DATA_W'(i * 16'h1111));
    base      = rx_q.size();
    base_ren  = ren_cnt;
    base_last = last_cnt;
    start_burst(8'd8);
    check("basic_busy_after_start", {31'd0, busy}, 32'd1);
    check("basic_words_left_init", {24'd0, words_left}, 32'd8);
    wait_done(100, seen, busy_v);
    check("basic_done_seen", {31'd0, seen}, 32'd1);
    check("basic_busy_with_done", {31'd0, busy_v}, 32'd0);
    check("basic_rx_count", rx_q.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("basic_rx_data", {16'd0, rx_q[base + i]}, (i + 1) * 32'h1111);
    end
    check("basic_ren_count", ren_cnt - base_ren, 32'd8);
    check("basic_last_count", last_cnt - base_last, 32'd1);
    check("basic_last_data", {16'd0, last_data}, 32'h8888);
    check("basic_done_latency", done_cyc - hs_cyc, 32'd1);
    check("basic_words_left_end", {24'd0, words_left}, 32'd0);
    tick();
    check("basic_done_one_cycle", {31'd0, done}, 32'd0);

    // Backpressure: 16 words, ready pattern 1,0,0,1.
    bp_mode = 1'b1;
    for (int i = 0; i < 16; i++) push(DATA_W'(16'h0100 + i));
    base = rx_q.size();
    start_burst(8'd16);
    wait_done(300, seen, busy_v);
    bp_mode = 1'b0;
    check("bp_done_seen", {31'd0, seen}, 32'd1);
    check("bp_rx_count", rx_q.size() - base, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("bp_rx_data", {16'd0, rx_q[base + i]}, 32'h0100 + i);
    end
    check("bp_last_data", {16'd0, last_data}, 32'h010F);
    check("bp_stall_stable", stall_viol, 32'd0);
    check("bp_occ_max_le2", {31'd0, occ_max <= 2}, 32'd1);

    // Empty stall: 3 of 5 words available.
    tick();
    for (int i = 1; i <= 3; i++) push(DATA_W'(16'h0A00 + i));
    base      = rx_q.size();
    base_done = done_cyc;
    start_burst(8'd5);
    repeat (30) tick();
    check("stall_rx_count", rx_q.size() - base, 32'd3);
    check("stall_no_done", done_cyc, base_done);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_words_left", {24'd0, words_left}, 32'd2);
    check("stall_no_ren_empty", ren_empty, 32'd0);
    push(16'h0A04);
    push(16'h0A05);
    wait_done(60, seen, busy_v);
    check("stall_done_seen", {31'd0, seen}, 32'd1);
    check("stall_rx_total", rx_q.size() - base, 32'd5);
    check("stall_rx_data4", {16'd0, rx_q[base + 3]}, 32'h0A04);
    check("stall_rx_data5", {16'd0, rx_q[base + 4]}, 32'h0A05);
    check("stall_last_data", {16'd0, last_data}, 32'h0A05);

    // Zero-length burst.
    tick();
    base_ren  = ren_cnt;
    start     = 1'b1;
    burst_len = 8'd0;
    @(negedge clk);
    #1;
    check("zero_done_not_yet", {31'd0, done}, 32'd0);
    tick();
    start = 1'b0;
    check("zero_done_pulse", {31'd0, done}, 32'd1);
    check("zero_busy_low", {31'd0, busy}, 32'd0);
    tick();
    check("zero_done_cleared", {31'd0, done}, 32'd0);
    check("zero_busy_still_low", {31'd0, busy}, 32'd0);
    check("zero_no_ren", ren_cnt - base_ren, 32'd0);

    // Mid-burst reset after 4 handshakes.
    for (int i = 0; i < 10; i++) push(DATA_W'(16'h0C00 + i));
    base = rx_q.size();
    start_burst(8'd10);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rx_q.size() - base >= 4) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_four_handshakes", {31'd0, seen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {16'd0, busy, done, bus.FIFO_r_en, bus.m_valid, bus.m_last, 3'd0,
                                words_left}, 32'd0);
    check("mid_reset_m_data", {16'd0, bus.m_data}, 32'd0);
`ifdef FIFO_RD_CHECKSUM_EN
    check("mid_reset_checksum", {16'd0, checksum}, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(16'h0D01);
    push(16'h0D02);
    base = rx_q.size();
    start_burst(8'd2);
    check("post_reset_words_left", {24'd0, words_left}, 32'd2);
    wait_done(60, seen, busy_v);
    check("post_reset_done_seen", {31'd0, seen}, 32'd1);
    check("post_reset_rx_count", rx_q.size() - base, 32'd2);
    check("post_reset_rx_data1", {16'd0, rx_q[base]}, 32'h0D01);
    check("post_reset_rx_data2", {16'd0, rx_q[base + 1]}, 32'h0D02);

`ifdef FIFO_RD_CHECKSUM_EN
    // Checksum of 0x1111..0x4444 is 0xAAAA, held after done.
    tick();
    for (int i = 1; i <= 4; i++) push(DATA_W'(i * 16'h1111));
    start_burst(8'd4);
    check("csum_cleared_on_start", {16'd0, checksum}, 32'd0);
    wait_done(60, seen, busy_v);
    check("csum_done_seen", {31'd0, seen}, 32'd1);
    check("csum_at_done", {16'd0, checksum}, 32'hAAAA);
    repeat (3) tick();
    check("csum_held", {16'd0, checksum}, 32'hAAAA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
